// File: rtl/ram_dp_sync.sv
// ram_dp_sync: simple dual-port synchronous RAM (one write port, one read
// port, single clock) with per-lane write enables, a selectable
// read-during-write collision mode, a registered read-valid flag and a
// hardware init sweep that writes INIT_VAL to every word after reset or clr.
module ram_dp_sync #(
    parameter int               WIDTH    = 8,
    parameter int               LANE_W   = 8,
    parameter int               ADDR_W   = 3,
    parameter int               RD_MODE  = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = {WIDTH{1'b0}}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      we,
    input  logic [WIDTH/LANE_W-1:0]   wr_be,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      busy
);

    localparam int                NLANE    = WIDTH / LANE_W;
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Replace the lanes of old_w selected by be with the matching lanes of new_w.
    function automatic logic [WIDTH-1:0] lane_merge(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NLANE-1:0] be
    );
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NLANE; i++) begin
            if (be[i]) begin
                res[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
            end else begin
                res[i*LANE_W +: LANE_W] = old_w[i*LANE_W +: LANE_W];
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [0:0]        state_r;
    logic [ADDR_W-1:0] ptr_r;

    logic              accept_s;
    logic              wr_fire_s;
    logic              rd_fire_s;
    logic              collide_s;
    logic [WIDTH-1:0]  merged_s;
    logic [WIDTH-1:0]  rd_word_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [WIDTH-1:0]  mem_wdata_s;

    // Port request qualification, lane merge and read-during-write selection.
    always_comb begin
        accept_s  = (state_r == ST_READY) && !clr;
        wr_fire_s = accept_s && we;
        rd_fire_s = accept_s && rd_en;
        collide_s = wr_fire_s && (wr_addr == rd_addr);
        merged_s  = lane_merge(mem_r[wr_addr], wr_data, wr_be);
        if (collide_s && (RD_MODE == 1)) begin
            rd_word_s = merged_s;
        end else begin
            rd_word_s = mem_r[rd_addr];
        end
    end

    // Array write source: the init sweep owns the port while not READY.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_addr;
        mem_wdata_s = merged_s;
        if (state_r == ST_INIT) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = ptr_r;
            mem_wdata_s = INIT_VAL;
        end else begin
            mem_we_s    = wr_fire_s;
            mem_waddr_s = wr_addr;
            mem_wdata_s = merged_s;
        end
    end

    // Storage array; contents are deliberately not reset, the sweep clears them.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control FSM, sweep pointer and registered read outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_INIT;
            ptr_r    <= PTR_ZERO;
            busy     <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    rd_valid <= 1'b0;
                    if (clr) begin
                        ptr_r <= PTR_ZERO;
                    end else if (ptr_r == PTR_LAST) begin
                        ptr_r   <= PTR_ZERO;
                        state_r <= ST_READY;
                        busy    <= 1'b0;
                    end else begin
                        ptr_r <= ptr_r + PTR_ONE;
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        state_r  <= ST_INIT;
                        ptr_r    <= PTR_ZERO;
                        busy     <= 1'b1;
                        rd_valid <= 1'b0;
                    end else begin
                        rd_valid <= rd_fire_s;
                        if (rd_fire_s) begin
                            rd_data <= rd_word_s;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_INIT;
                    ptr_r    <= PTR_ZERO;
                    busy     <= 1'b1;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dp_sync.sv
// Directed bench for ram_dp_sync: two instances (read-first and write-first)
// share all stimulus; outputs are compared against hand-computed values.
module tb_ram_dp_sync;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        we;
    logic [1:0]  wr_be;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    ram_dp_sync #(.WIDTH(16), .LANE_W(8), .ADDR_W(3), .RD_MODE(0), .INIT_VAL(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .wr_be(wr_be),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0));

    ram_dp_sync #(.WIDTH(16), .LANE_W(8), .ADDR_W(3), .RD_MODE(1), .INIT_VAL(16'h0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .wr_be(wr_be),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        re;
        logic [2:0]  ra;
        logic        ev;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    vec_t vec [32];
    int   nv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [1:0] be, input logic [2:0] wa,
                       input logic [15:0] wd, input logic r, input logic [2:0] ra,
                       input logic ev, input logic [15:0] e0, input logic [15:0] e1);
        vec[nv] = '{we: w, be: be, wa: wa, wd: wd, re: r, ra: ra, ev: ev, e0: e0, e1: e1};
        nv++;
    endtask

    task automatic drive(input logic c, input logic w, input logic [1:0] be, input logic [2:0] wa,
                         input logic [15:0] wd, input logic r, input logic [2:0] ra);
        clr = c; we = w; wr_be = be; wr_addr = wa; wr_data = wd; rd_en = r; rd_addr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops (bounded) and checks the count.
    task automatic busy_len(input string name);
        int n;
        n = 0;
        drive(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 3'd0);
        while (busy0 && n < 20) begin
            tick();
            n++;
        end
        chk(name, n, 8);
        chk({name, "_dut1"}, {31'd0, busy1}, 32'd0);
    endtask

    task automatic read_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
        drive(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, a);
        tick();
        chk({name, "_valid"}, {31'd0, rd_valid0}, 32'd1);
        chk({name, "_data0"}, {16'd0, rd_data0}, {16'd0, exp});
        chk({name, "_data1"}, {16'd0, rd_data1}, {16'd0, exp});
    endtask

    initial begin
        drive(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 3'd0);
        rst_n = 1'b0;

        // Directed table (applied after the first sweep completes).
        for (int i = 0; i < 8; i++) add(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'(i), 1'b1, 16'h0000, 16'h0000);
        add(1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000); // idle
        add(1'b1, 2'b11, 3'd5, 16'hA5C3, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
        add(1'b1, 2'b01, 3'd5, 16'hFF00, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
        add(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b1, 16'hA500, 16'hA500);
        add(1'b1, 2'b11, 3'd2, 16'h1234, 1'b0, 3'd0, 1'b0, 16'hA500, 16'hA500);
        add(1'b1, 2'b11, 3'd2, 16'hBEEF, 1'b1, 3'd2, 1'b1, 16'h1234, 16'hBEEF); // collision, full word
        add(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b1, 16'hBEEF, 16'hBEEF);
        add(1'b1, 2'b11, 3'd2, 16'h1234, 1'b0, 3'd0, 1'b0, 16'hBEEF, 16'hBEEF);
        add(1'b1, 2'b10, 3'd2, 16'hBEEF, 1'b1, 3'd2, 1'b1, 16'h1234, 16'hBE34); // collision, upper lane
        add(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b1, 16'hBE34, 16'hBE34);
        add(1'b1, 2'b11, 3'd6, 16'h6666, 1'b0, 3'd0, 1'b0, 16'hBE34, 16'hBE34);
        add(1'b1, 2'b11, 3'd1, 16'h1111, 1'b1, 3'd6, 1'b1, 16'h6666, 16'h6666); // different addresses
        add(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd1, 1'b1, 16'h1111, 16'h1111);
        add(1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h1111, 16'h1111); // hold
        add(1'b1, 2'b00, 3'd4, 16'h4444, 1'b0, 3'd0, 1'b0, 16'h1111, 16'h1111); // be = 0
        add(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b1, 16'h0000, 16'h0000);
        add(1'b0, 2'b00, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b1, 16'hA500, 16'hA500);

        // Reset state
        #12;
        chk("rst_busy",  {31'd0, busy0},     32'd1);
        chk("rst_valid", {31'd0, rd_valid0}, 32'd0);
        chk("rst_data",  {16'd0, rd_data0},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_len("busy_len_reset");

        // Table
        for (int i = 0; i < nv; i++) begin
            drive(1'b0, vec[i].we, vec[i].be, vec[i].wa, vec[i].wd, vec[i].re, vec[i].ra);
            tick();
            chk($sformatf("vec%0d_valid0", i), {31'd0, rd_valid0}, {31'd0, vec[i].ev});
            chk($sformatf("vec%0d_valid1", i), {31'd0, rd_valid1}, {31'd0, vec[i].ev});
            chk($sformatf("vec%0d_data0", i),  {16'd0, rd_data0},  {16'd0, vec[i].e0});
            chk($sformatf("vec%0d_data1", i),  {16'd0, rd_data1},  {16'd0, vec[i].e1});
        end

        // Fill all words, then clr together with a write and a read
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 2'b11, 3'(i), 16'h1000 + 16'(i) * 16'h0101, 1'b0, 3'd0);
            tick();
        end
        read_chk("fill_rd7", 3'd7, 16'h1707);
        drive(1'b1, 1'b1, 2'b11, 3'd3, 16'hFFFF, 1'b1, 3'd3);
        tick();
        chk("clr_busy",  {31'd0, busy0},     32'd1);
        chk("clr_valid", {31'd0, rd_valid0}, 32'd0);
        chk("clr_hold",  {16'd0, rd_data0},  32'h0000_1707);
        busy_len("busy_len_clr");
        for (int i = 0; i < 8; i++) read_chk($sformatf("clr_rd%0d", i), 3'(i), 16'h0000);

        // Reset in the middle of a sweep
        drive(1'b0, 1'b1, 2'b11, 3'd3, 16'h3333, 1'b0, 3'd0);
        tick();
        read_chk("pre_rst_rd3", 3'd3, 16'h3333);
        drive(1'b1, 1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 3'd0);
        tick();
        drive(1'b0, 1'b0, 2'b00, 3'd0, 16'h0000, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("sweep_busy", {31'd0, busy0},    32'd1);
        chk("sweep_hold", {16'd0, rd_data0}, 32'h0000_3333);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  {31'd0, busy0},     32'd1);
        chk("midrst_valid", {31'd0, rd_valid0}, 32'd0);
        chk("midrst_data0", {16'd0, rd_data0},  32'd0);
        chk("midrst_data1", {16'd0, rd_data1},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        busy_len("busy_len_midrst");
        read_chk("post_rst_rd3", 3'd3, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_dp_sync.md
# ram_dp_sync

Parametrised simple-dual-port synchronous RAM: one write port and one read port share a single clock. It adds per-lane write enables, a selectable read-during-write collision mode, a registered read-valid flag, and a hardware init sweep that zeroes the array after reset or on request. It is the general storage primitive for register files, line buffers and FIFO backing stores in the memory subsystem.

## Interface
- WIDTH, 8: data word width in bits; must be a multiple of LANE_W.
- LANE_W, 8: write-enable granularity in bits; NLANE = WIDTH/LANE_W.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W words.
- RD_MODE, 0: collision mode; 0 = read-first (old data), 1 = write-first (new data).
- INIT_VAL, 0: WIDTH-bit value written to every word by the init sweep.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous request to re-run the init sweep.
- we  in  1  write request.
- wr_be  in  NLANE  lane enables; bit i covers data bits [i*LANE_W +: LANE_W].
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  rd_data was updated by the previous cycle's accepted read.
- busy  out  1  init sweep in progress; all port requests are ignored.

## Operation
- FSM states: INIT and READY.
- Reset (rst_n low, asynchronous): state = INIT, sweep pointer = 0, busy = 1, rd_valid = 0, rd_data = 0. Array contents are not reset directly.
- INIT: each cycle writes INIT_VAL to word[ptr], then ptr++. When ptr = DEPTH-1 is written, go to READY; busy deasserts from the next cycle.
  - we, rd_en and wr_be are ignored; rd_valid stays 0.
  - clr during INIT restarts the sweep at ptr = 0.
- READY:
  - clr = 1: go to INIT, ptr = 0. Any we/rd_en in the same cycle is ignored (clr has priority).
  - Write: we = 1 updates only the lanes of word[wr_addr] whose wr_be bit is 1. If wr_be = 0, the word is unchanged.
  - Read: rd_en = 1 loads rd_data and sets rd_valid = 1 for one cycle. If rd_en = 0, rd_valid = 0 and rd_data holds its last value (never X).
  - Collision (we and rd_en in the same cycle with wr_addr = rd_addr):
    - RD_MODE 0: rd_data = word value before the write.
    - RD_MODE 1: rd_data = merged word, i.e. wr_data lanes where wr_be = 1, old lanes elsewhere.
    - Memory is updated identically in both modes.
  - Accesses to different addresses are fully independent.
- Reset asserted mid-sweep or mid-operation aborts immediately to reset values. The sweep restarts after rst_n rises; partially swept contents are not relied upon.

## Timing
- Read latency is 1: a request sampled at edge k makes rd_data and rd_valid valid after edge k; rd_valid is high for exactly one cycle per accepted read.
- Write latency is 1: data written at edge k is readable by a read sampled at edge k+1. Same-edge reads follow RD_MODE.
- After rst_n rises, busy stays high for exactly DEPTH rising edges. The first request is accepted at the edge after busy falls.
- clr sampled at edge k in READY: busy = 1 after edge k, for DEPTH edges.
- Back-to-back reads and writes are accepted every cycle in READY; there is no throughput stall.

## Test plan
- Reset then idle, WIDTH=16, ADDR_W=3 -> busy high for 8 cycles; subsequent reads of addresses 0..7 all return 0x0000 with rd_valid pulsing once per read.
- Write 0xA5C3 to address 5 with wr_be=2'b11, then write 0xFF00 with wr_be=2'b01 -> read of address 5 returns 0xA500.
- RD_MODE=0, word 2 = 0x1234; same-cycle write 0xBEEF (be=2'b11) and read of address 2 -> rd_data = 0x1234; next read returns 0xBEEF. Repeat with RD_MODE=1 and be=2'b10 -> rd_data = 0xBE34.
- Simultaneous write to address 1 and read of address 6 -> read returns the prior word 6 value; word 1 is updated.
- Fill all words, pulse clr together with we to address 3 -> write ignored; busy high for 8 cycles; all words read back INIT_VAL.
- Assert rst_n low at sweep pointer 4 -> busy=1, rd_valid=0, rd_data=0 immediately; after release busy lasts a full 8 cycles.
